// File: rtl/inst_fetch_queue.sv
// Instruction fetch front end: sequential PC generation with a single outstanding
// memory request, an instruction/PC FIFO towards decode, and commit redirect handling.
module inst_fetch_queue #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          QLOG     = 3
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    input  logic        rdy_in,
    output logic        mem_req_o,
    output logic [31:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [31:0] mem_data_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [31:0] out_inst_o,
    output logic [31:0] out_pc_o,
    input  logic        flush_i,
    input  logic [31:0] flush_pc_i
);

    localparam int              DEPTH    = 1 << QLOG;
    localparam logic [QLOG:0]   DEPTH_C  = (QLOG + 1)'(DEPTH);
    localparam logic [QLOG-1:0] PTR_ZERO = {QLOG{1'b0}};
    localparam logic [QLOG:0]   CNT_ZERO = {(QLOG + 1){1'b0}};

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    state_t          state_r, state_s;
    logic [31:0]     pc_r, pc_s;
    logic [QLOG-1:0] head_r, head_s, tail_r, tail_s;
    logic [QLOG:0]   count_r, count_s;
    logic            mem_req_r, mem_req_s;
    logic [31:0]     mem_addr_r, mem_addr_s;
    logic            out_valid_r, out_valid_s;
    logic [31:0]     out_inst_r, out_inst_s;
    logic [31:0]     out_pc_r, out_pc_s;
    logic            push_s, pop_s;
    logic [31:0]     inst_q_r [DEPTH];
    logic [31:0]     pc_q_r   [DEPTH];
    logic [1:0]      unused_flush_lsb_s;

    assign unused_flush_lsb_s = flush_pc_i[1:0];

    assign mem_req_o   = mem_req_r;
    assign mem_addr_o  = mem_addr_r;
    assign out_valid_o = out_valid_r;
    assign out_inst_o  = out_inst_r;
    assign out_pc_o    = out_pc_r;

    // Next-state, fetch handshake and queue bookkeeping
    always_comb begin
        state_s     = state_r;
        pc_s        = pc_r;
        head_s      = head_r;
        tail_s      = tail_r;
        count_s     = count_r;
        mem_req_s   = mem_req_r;
        mem_addr_s  = mem_addr_r;
        out_valid_s = out_valid_r;
        out_inst_s  = out_inst_r;
        out_pc_s    = out_pc_r;
        push_s      = 1'b0;
        pop_s       = 1'b0;
        if (!rdy_in) begin
            state_s = state_r;
        end else if (flush_i) begin
            pc_s        = {flush_pc_i[31:2], 2'b00};
            head_s      = PTR_ZERO;
            tail_s      = PTR_ZERO;
            count_s     = CNT_ZERO;
            out_valid_s = 1'b0;
            // An outstanding request must still see its ack before a new one may start
            case (state_r)
                ST_WAIT, ST_DISCARD: begin
                    if (mem_ack_i) begin
                        state_s   = ST_IDLE;
                        mem_req_s = 1'b0;
                    end else begin
                        state_s   = ST_DISCARD;
                        mem_req_s = 1'b1;
                    end
                end
                default: begin
                    state_s   = ST_IDLE;
                    mem_req_s = 1'b0;
                end
            endcase
        end else begin
            pop_s = (count_r != CNT_ZERO) && out_ready_i;
            case (state_r)
                ST_IDLE: begin
                    if (count_r < DEPTH_C) begin
                        state_s    = ST_WAIT;
                        mem_req_s  = 1'b1;
                        mem_addr_s = pc_r;
                    end else begin
                        state_s = ST_IDLE;
                    end
                end
                ST_WAIT: begin
                    if (mem_ack_i) begin
                        push_s    = 1'b1;
                        pc_s      = pc_r + 32'd4;
                        mem_req_s = 1'b0;
                        state_s   = ST_IDLE;
                    end else begin
                        state_s = ST_WAIT;
                    end
                end
                ST_DISCARD: begin
                    if (mem_ack_i) begin
                        mem_req_s = 1'b0;
                        state_s   = ST_IDLE;
                    end else begin
                        state_s = ST_DISCARD;
                    end
                end
                default: begin
                    mem_req_s = 1'b0;
                    state_s   = ST_IDLE;
                end
            endcase

            if (push_s) begin
                tail_s = tail_r + QLOG'(1);
            end else begin
                tail_s = tail_r;
            end
            if (pop_s) begin
                head_s = head_r + QLOG'(1);
            end else begin
                head_s = head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + (QLOG + 1)'(1);
                2'b01:   count_s = count_r - (QLOG + 1)'(1);
                default: count_s = count_r;
            endcase

            // Head registers track the entry that will sit at head next cycle
            out_valid_s = (count_s != CNT_ZERO);
            if (push_s && (tail_r == head_s)) begin
                out_inst_s = mem_data_i;
                out_pc_s   = pc_r;
            end else begin
                out_inst_s = inst_q_r[head_s];
                out_pc_s   = pc_q_r[head_s];
            end
        end
    end

    // Control, pointer and output registers
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_r     <= ST_IDLE;
            pc_r        <= RESET_PC;
            head_r      <= PTR_ZERO;
            tail_r      <= PTR_ZERO;
            count_r     <= CNT_ZERO;
            mem_req_r   <= 1'b0;
            mem_addr_r  <= 32'h0000_0000;
            out_valid_r <= 1'b0;
            out_inst_r  <= 32'h0000_0000;
            out_pc_r    <= 32'h0000_0000;
        end else begin
            state_r     <= state_s;
            pc_r        <= pc_s;
            head_r      <= head_s;
            tail_r      <= tail_s;
            count_r     <= count_s;
            mem_req_r   <= mem_req_s;
            mem_addr_r  <= mem_addr_s;
            out_valid_r <= out_valid_s;
            out_inst_r  <= out_inst_s;
            out_pc_r    <= out_pc_s;
        end
    end

    // Queue storage, written only on an accepted fetch
    always_ff @(posedge clk_in) begin
        if (push_s) begin
            inst_q_r[tail_r] <= mem_data_i;
            pc_q_r[tail_r]   <= pc_r;
        end
    end

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed vector table, corner-case sequences and
// randomized traffic checked against a queue-based reference model.
module tb_inst_fetch_queue;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic        rdy_in;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic [31:0] out_inst_o;
    logic [31:0] out_pc_o;
    logic        flush_i;
    logic [31:0] flush_pc_i;

    int n_tests = 0;
    int n_fail  = 0;

    inst_fetch_queue dut (
        .clk_in      (clk_in),
        .rst_n_in    (rst_n_in),
        .rdy_in      (rdy_in),
        .mem_req_o   (mem_req_o),
        .mem_addr_o  (mem_addr_o),
        .mem_ack_i   (mem_ack_i),
        .mem_data_i  (mem_data_i),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i),
        .out_inst_o  (out_inst_o),
        .out_pc_o    (out_pc_o),
        .flush_i     (flush_i),
        .flush_pc_i  (flush_pc_i)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: a queue of {inst, pc}, the fetch PC, and whether a request
    // is outstanding and whether its data is to be thrown away.
    logic [63:0] m_q [$];
    logic [31:0] m_pc;
    logic [31:0] m_addr;
    logic        m_req;
    logic        m_disc;

    typedef struct {
        logic        ack;
        logic [31:0] data;
        logic        ready;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_pc   = 32'h0;
        m_addr = 32'h0;
        m_req  = 1'b0;
        m_disc = 1'b0;
    endtask

    task automatic model_step(input logic rdy, input logic ack, input logic [31:0] data,
                              input logic ready, input logic flush, input logic [31:0] fpc);
        int sz;
        if (!rdy) return;
        if (flush) begin
            m_q.delete();
            m_pc = {fpc[31:2], 2'b00};
            if (m_req) begin
                if (ack) begin
                    m_req  = 1'b0;
                    m_disc = 1'b0;
                end else begin
                    m_disc = 1'b1;
                end
            end
            return;
        end
        sz = m_q.size();
        if (sz > 0 && ready) void'(m_q.pop_front());
        if (!m_req) begin
            if (sz < 8) begin
                m_req  = 1'b1;
                m_addr = m_pc;
            end
        end else if (ack) begin
            if (!m_disc) begin
                m_q.push_back({data, m_pc});
                m_pc = m_pc + 32'd4;
            end
            m_req  = 1'b0;
            m_disc = 1'b0;
        end
    endtask

    task automatic model_check();
        chk("model_req", {31'b0, mem_req_o}, {31'b0, m_req});
        if (m_req) chk("model_addr", mem_addr_o, m_addr);
        chk("model_valid", {31'b0, out_valid_o}, {31'b0, (m_q.size() != 0)});
        if (m_q.size() != 0) begin
            chk("model_inst", out_inst_o, m_q[0][63:32]);
            chk("model_pc", out_pc_o, m_q[0][31:0]);
        end
    endtask

    task automatic cyc(input logic rdy, input logic ack, input logic [31:0] data,
                       input logic ready, input logic flush, input logic [31:0] fpc);
        rdy_in      = rdy;
        mem_ack_i   = ack;
        mem_data_i  = data;
        out_ready_i = ready;
        flush_i     = flush;
        flush_pc_i  = fpc;
        @(posedge clk_in);
        model_step(rdy, ack, data, ready, flush, fpc);
        #1;
        model_check();
    endtask

    task automatic step(input logic ack, input logic [31:0] data, input logic ready);
        cyc(1'b1, ack, data, ready, 1'b0, 32'h0);
    endtask

    task automatic do_reset();
        rdy_in      = 1'b0;
        mem_ack_i   = 1'b0;
        mem_data_i  = 32'h0;
        out_ready_i = 1'b0;
        flush_i     = 1'b0;
        flush_pc_i  = 32'h0;
        rst_n_in    = 1'b0;
        #2;
        model_reset();
        chk("rst_req", {31'b0, mem_req_o}, 32'h0);
        chk("rst_addr", mem_addr_o, 32'h0);
        chk("rst_valid", {31'b0, out_valid_o}, 32'h0);
        chk("rst_inst", out_inst_o, 32'h0);
        chk("rst_pc", out_pc_o, 32'h0);
        @(negedge clk_in);
        rst_n_in = 1'b1;
        @(posedge clk_in);
        #1;
    endtask

    initial begin
        int acks;
        int k;
        int got;
        logic        a;
        logic [31:0] exp_pc;

        //            ack   data          rdy   req   addr          valid pc            inst
        vecs[0] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h0,        1'b0, 32'h0,        32'h0};
        vecs[1] = '{1'b1, 32'h13,       1'b0, 1'b0, 32'h0,        1'b1, 32'h0,        32'h13};
        vecs[2] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'h4,        1'b1, 32'h0,        32'h13};
        vecs[3] = '{1'b1, 32'h17,       1'b1, 1'b0, 32'h0,        1'b1, 32'h4,        32'h17};
        vecs[4] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h8,        1'b0, 32'h0,        32'h0};
        vecs[5] = '{1'b1, 32'h1b,       1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h1b};
        vecs[6] = '{1'b0, 32'h0,        1'b0, 1'b1, 32'hc,        1'b1, 32'h8,        32'h1b};
        vecs[7] = '{1'b1, 32'h1f,       1'b0, 1'b0, 32'h0,        1'b1, 32'h8,        32'h1b};
        vecs[8] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       1'b1, 32'hc,        32'h1f};
        vecs[9] = '{1'b0, 32'h0,        1'b1, 1'b1, 32'h10,       1'b0, 32'h0,        32'h0};

        // Directed table: sequential fetch with interleaved pops
        do_reset();
        for (int i = 0; i < 10; i++) begin
            step(vecs[i].ack, vecs[i].data, vecs[i].ready);
            chk($sformatf("vec%0d_req", i), {31'b0, mem_req_o}, {31'b0, vecs[i].exp_req});
            if (vecs[i].exp_req) chk($sformatf("vec%0d_addr", i), mem_addr_o, vecs[i].exp_addr);
            chk($sformatf("vec%0d_valid", i), {31'b0, out_valid_o}, {31'b0, vecs[i].exp_valid});
            if (vecs[i].exp_valid) begin
                chk($sformatf("vec%0d_pc", i), out_pc_o, vecs[i].exp_pc);
                chk($sformatf("vec%0d_inst", i), out_inst_o, vecs[i].exp_inst);
            end
        end

        // Fill to DEPTH with no pops, then one pop lets fetch resume at 0x20
        do_reset();
        acks = 0;
        for (int i = 0; i < 60; i++) begin
            a = mem_req_o;
            if (a) acks++;
            step(a, 32'h13 + mem_addr_o, 1'b0);
        end
        chk("full_acks", acks, 32'd8);
        chk("full_noreq", {31'b0, mem_req_o}, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("full_pop_head", out_pc_o, 32'h4);
        chk("full_pop_noreq", {31'b0, mem_req_o}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("refill_req", {31'b0, mem_req_o}, 32'h1);
        chk("refill_addr", mem_addr_o, 32'h20);

        // Flush while waiting on 0x10; the late ack's data must be dropped
        do_reset();
        k = 0;
        while (!(mem_req_o && mem_addr_o == 32'h10) && k < 40) begin
            a = mem_req_o;
            step(a, 32'h13 + mem_addr_o, 1'b0);
            k++;
        end
        chk("reach_wait_0x10", {31'b0, (mem_req_o && mem_addr_o == 32'h10)}, 32'h1);
        cyc(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 32'h1003);
        chk("flush_empty", {31'b0, out_valid_o}, 32'h0);
        chk("flush_req_held", {31'b0, mem_req_o}, 32'h1);
        for (int i = 0; i < 2; i++) begin
            step(1'b0, 32'h0, 1'b0);
            chk("discard_req_held", {31'b0, mem_req_o}, 32'h1);
            chk("discard_empty", {31'b0, out_valid_o}, 32'h0);
        end
        step(1'b1, 32'hDEADBEEF, 1'b0);
        chk("discard_ack_req", {31'b0, mem_req_o}, 32'h0);
        chk("discard_ack_empty", {31'b0, out_valid_o}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("redirect_req", {31'b0, mem_req_o}, 32'h1);
        chk("redirect_addr", mem_addr_o, 32'h1000);
        step(1'b1, 32'h55, 1'b0);
        chk("redirect_valid", {31'b0, out_valid_o}, 32'h1);
        chk("redirect_pc", out_pc_o, 32'h1000);
        chk("redirect_inst", out_inst_o, 32'h55);

        // Flush and ack in the same cycle: no discard state
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        cyc(1'b1, 1'b1, 32'hBAD, 1'b0, 1'b1, 32'h200);
        chk("flushack_req", {31'b0, mem_req_o}, 32'h0);
        chk("flushack_valid", {31'b0, out_valid_o}, 32'h0);
        step(1'b0, 32'h0, 1'b0);
        chk("flushack_next_req", {31'b0, mem_req_o}, 32'h1);
        chk("flushack_next_addr", mem_addr_o, 32'h200);

        // Streaming: push and pop every fetch, pointers wrap twice
        do_reset();
        exp_pc = 32'h0;
        got = 0;
        k = 0;
        while (got < 20 && k < 200) begin
            if (out_valid_o) begin
                chk("stream_pc", out_pc_o, exp_pc);
                chk("stream_inst", out_inst_o, 32'h13 + exp_pc);
                exp_pc = exp_pc + 32'd4;
                got++;
            end
            a = mem_req_o;
            step(a, 32'h13 + mem_addr_o, 1'b1);
            k++;
        end
        chk("stream_count", got, 32'd20);

        // Global enable low mid-WAIT: acks and flushes ignored
        do_reset();
        step(1'b0, 32'h0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, (i % 2) == 0, 32'h99, 1'b1, i == 2, 32'h444);
            chk("hold_req", {31'b0, mem_req_o}, 32'h1);
            chk("hold_addr", mem_addr_o, 32'h0);
            chk("hold_valid", {31'b0, out_valid_o}, 32'h0);
        end
        step(1'b1, 32'h13, 1'b0);
        chk("resume_valid", {31'b0, out_valid_o}, 32'h1);
        chk("resume_inst", out_inst_o, 32'h13);
        chk("resume_pc", out_pc_o, 32'h0);
        step(1'b0, 32'h0, 1'b1);
        chk("resume_single_push", {31'b0, out_valid_o}, 32'h0);
        chk("resume_next_addr", mem_addr_o, 32'h4);

        // Reset mid-transaction: a stale ack in IDLE is ignored
        step(1'b0, 32'h0, 1'b0);
        do_reset();
        step(1'b1, 32'hBAD, 1'b0);
        chk("stale_ack_valid", {31'b0, out_valid_o}, 32'h0);
        chk("stale_ack_addr", mem_addr_o, 32'h0);

        // Randomized traffic against the reference model
        do_reset();
        for (int i = 0; i < 800; i++) begin
            cyc(($urandom % 10) != 0,
                mem_req_o ? (($urandom % 3) == 0) : (($urandom % 8) == 0),
                $urandom,
                ($urandom % 2) == 0,
                ($urandom % 25) == 0,
                $urandom);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/inst_fetch_queue.md
Name: inst_fetch_queue

Overview:
- Front-end controller that sequences instruction supply to the decoder.
- Generates sequential fetch PCs and runs a one-outstanding request/ack handshake with the memory controller.
- Buffers returned instruction words with their PCs in a FIFO, then presents them to the decode/issue stage under a valid/ready handshake.
- Accepts a redirect (flush) from commit: discards the queue and any in-flight fetch, then restarts at the new PC.

Parameters:
- RESET_PC, 32'h00000000, PC of the first fetch after reset.
- QLOG, 3, log2 of queue depth; depth is DEPTH = 2**QLOG entries.

Ports:
- clk_in  input  1  clock; all state updates on rising edge.
- rst_n_in  input  1  asynchronous active-low reset.
- rdy_in  input  1  global enable; when 0, all state holds.
- mem_req_o  output  1  fetch request, held high until acknowledged.
- mem_addr_o  output  32  fetch address, stable while mem_req_o=1.
- mem_ack_i  input  1  one-cycle pulse: mem_data_i holds the word for the current request.
- mem_data_i  input  32  fetched instruction word.
- out_valid_o  output  1  queue head is valid.
- out_ready_i  input  1  downstream accepts the head this cycle.
- out_inst_o  output  32  instruction word at queue head, fed to the decoder.
- out_pc_o  output  32  PC of the head instruction.
- flush_i  input  1  redirect request from commit (mispredict or jump).
- flush_pc_i  input  32  new fetch PC; bits [1:0] are forced to 0.

Behaviour:
- Reset (async, rst_n_in=0):
  - pc=RESET_PC, FSM=IDLE, queue empty (head=tail=count=0).
  - mem_req_o=0, mem_addr_o=0, out_valid_o=0, out_inst_o=0, out_pc_o=0.
  - Reset asserted mid-transaction abandons the transaction; any ack arriving afterwards in IDLE is ignored.
- rdy_in=0: no state changes, outputs hold, mem_req_o keeps its value, mem_ack_i and flush_i are ignored.
- FSM states:
  - IDLE: if count<DEPTH and no flush, the next cycle has FSM=WAIT, mem_req_o=1, mem_addr_o=pc.
  - WAIT: on mem_ack_i=1, push {mem_data_i, pc} at tail; pc<=pc+4 (32-bit wrap); mem_req_o<=0; FSM<=IDLE.
  - DISCARD: entered on a flush while in WAIT with no ack that cycle. mem_req_o stays 1 until ack. On ack the data is dropped, mem_req_o<=0, FSM<=IDLE.
- A new request can start no earlier than the cycle after an ack; at most one request is outstanding.
- Fetch is requested only when count<DEPTH. Count cannot rise while a request is outstanding, so a push never overflows.
- Output port: out_valid_o = (count!=0); out_inst_o/out_pc_o show the head entry.
- Pop: out_valid_o && out_ready_i pops at the edge. Push and pop in the same cycle leave count unchanged.
- Latency: ack at edge N makes the word visible at out_*_o from cycle N+1. The bypass from mem_data_i to the output is intentionally absent.
- Pointers are QLOG bits wide and wrap modulo DEPTH; count is QLOG+1 bits.
- Flush (highest priority):
  - Queue is cleared (count=0, head=tail).
  - pc<={flush_pc_i[31:2],2'b00}.
  - out_valid_o=0 from the next cycle; a pop or push in the same cycle is cancelled.
  - State after flush:
    - IDLE: stays IDLE; the next fetch uses the new pc.
    - WAIT with ack in the same cycle: the ack ends the transaction, data is dropped, FSM<=IDLE, mem_req_o<=0.
    - WAIT without ack: FSM<=DISCARD.
    - DISCARD: stays DISCARD and the pc is updated again. Last flush wins.
- Empty with out_ready_i=1: no effect.
- Full: FSM stays IDLE until a pop.

Test Plan:
- Reset, then mem acks every 2nd cycle returning 0x00000013 + 4*k -> requests at 0x0,0x4,0x8,...; out_pc_o=0x0 with out_valid_o=1 one cycle after the first ack; ordering preserved.
- out_ready_i=0 with DEPTH=8 -> exactly 8 acks accepted, then mem_req_o stays 0. One pop -> the next request is addr 0x20.
- Flush with flush_pc_i=0x1003 while WAIT on addr 0x10, ack 3 cycles later with 0xDEADBEEF -> queue empties the next cycle; 0xDEADBEEF never appears at the output; next request addr=0x1000.
- flush_i and mem_ack_i in the same cycle (flush_pc_i=0x200) -> data dropped, no DISCARD, next mem_addr_o=0x200, out_valid_o=0.
- Continuous push+pop with out_ready_i=1 across 20 instructions -> count ≤1, pointers wrap cleanly, PCs consecutive.
- rdy_in=0 for 5 cycles mid-WAIT with ack pulsing -> no push, no state change. Resume with rdy_in=1 and ack -> single push of the correct word.
